// File: rtl/tick_divider_bank.sv
// Bank of independent programmable clock-enable generators: each channel emits a one-cycle
// tick every div_act enabled cycles plus a square wave. Optional macro TICK_SYNC_EN adds a sync restart port.
module tick_divider_bank #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 24,
  parameter int DIV_INIT = 100000,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] en,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [CNT_W-1:0]    wr_div,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sq,
  output logic                wr_err
`ifdef TICK_SYNC_EN
  ,
  input  logic                sync
`endif
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_INIT);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

  logic wr_ok;
  logic wr_err_reg;

  // One extra bit on the channel index so a full-range wr_ch can be compared against CHANNELS.
  assign wr_ok  = wr_en && (wr_div != '0) && ({1'b0, wr_ch} < CH_LIMIT);
  assign wr_err = wr_err_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_err_reg <= 1'b0;
    end else begin
      wr_err_reg <= wr_en && !wr_ok;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);

      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] div_reg;
      logic [CNT_W-1:0] pend_reg;
      logic             pend_vld_reg;
      logic             tick_reg;
      logic             sq_reg;
      logic             wr_hit;
      logic             wrap;

      assign wr_hit  = wr_ok && (wr_ch == CH_IDX);
      assign wrap    = (cnt_reg == div_reg - 1'b1);
      assign tick[gi] = tick_reg;
      assign sq[gi]   = sq_reg;

      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          cnt_reg      <= '0;
          div_reg      <= DIV_RST;
          pend_reg     <= '0;
          pend_vld_reg <= 1'b0;
          tick_reg     <= 1'b0;
          sq_reg       <= 1'b0;
        end
`ifdef TICK_SYNC_EN
        else if (sync) begin
          cnt_reg  <= '0;
          tick_reg <= 1'b0;
          sq_reg   <= 1'b0;
          // A write alongside sync loads directly so all channels restart on their new divisors.
          if (wr_hit) begin
            div_reg      <= wr_div;
            pend_vld_reg <= 1'b0;
          end else if (pend_vld_reg) begin
            div_reg      <= pend_reg;
            pend_vld_reg <= 1'b0;
          end
        end
`endif
        else if (en[gi]) begin
          if (wrap) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
            sq_reg   <= ~sq_reg;
            if (pend_vld_reg) begin
              div_reg <= pend_reg;
            end
          end else begin
            cnt_reg  <= cnt_reg + 1'b1;
            tick_reg <= 1'b0;
          end
          // The wrap consumes the old pending value; a coinciding write queues for the next wrap.
          if (wr_hit) begin
            pend_reg     <= wr_div;
            pend_vld_reg <= 1'b1;
          end else if (wrap) begin
            pend_vld_reg <= 1'b0;
          end
        end else begin
          tick_reg <= 1'b0;
          if (wr_hit) begin
            div_reg      <= wr_div;
            cnt_reg      <= '0;
            pend_vld_reg <= 1'b0;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_tick_divider_bank.sv
// Self-checking bench for tick_divider_bank: vector table, hand-written corner sequences and
// randomized traffic compared every cycle against a countdown-based reference model.
module tb_tick_divider_bank;

  localparam int NCH = 3;

  logic       clk;
  logic       rst_n;
  logic [2:0] en;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_div;
  logic [2:0] tick;
  logic [2:0] sq;
  logic       wr_err;
  logic       sync_in;

  tick_divider_bank #(.CHANNELS(3), .CNT_W(8), .DIV_INIT(5)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .en(en),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_div(wr_div),
    .tick(tick),
    .sq(sq),
    .wr_err(wr_err)
`ifdef TICK_SYNC_EN
    ,
    .sync(sync_in)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per channel, enabled edges remaining until the next tick.
  int         m_left [NCH];
  int         m_div  [NCH];
  int         m_pend [NCH];
  bit         m_pv   [NCH];
  logic [2:0] m_tick;
  logic [2:0] m_sq;
  logic       m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc_any;
    acc_any = 0;
    for (int c = 0; c < NCH; c++) begin
      bit acc;
      acc = wr_en && (wr_div != 0) && (int'(wr_ch) == c);
      if (acc) acc_any = 1;
      if (!rst_n) begin
        m_div[c] = 5; m_left[c] = 5; m_pv[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
      end else if (sync_in) begin
        if (acc) begin
          m_div[c] = wr_div; m_pv[c] = 0;
        end else if (m_pv[c]) begin
          m_div[c] = m_pend[c]; m_pv[c] = 0;
        end
        m_left[c] = m_div[c]; m_tick[c] = 0; m_sq[c] = 0;
      end else if (en[c]) begin
        m_left[c]--;
        if (m_left[c] == 0) begin
          m_tick[c] = 1;
          m_sq[c] = ~m_sq[c];
          if (m_pv[c]) begin
            m_div[c] = m_pend[c]; m_pv[c] = 0;
          end
          m_left[c] = m_div[c];
        end else begin
          m_tick[c] = 0;
        end
        if (acc) begin
          m_pend[c] = wr_div; m_pv[c] = 1;
        end
      end else begin
        m_tick[c] = 0;
        if (acc) begin
          m_div[c] = wr_div; m_left[c] = wr_div; m_pv[c] = 0;
        end
      end
    end
    m_err = rst_n && wr_en && !acc_any;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("model_tick", 32'(tick), 32'(m_tick));
    check("model_sq", 32'(sq), 32'(m_sq));
    check("model_wr_err", 32'(wr_err), 32'(m_err));
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_ch = 0; wr_div = 0; sync_in = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0; en = 0;
    repeat (3) step();
    rst_n = 1;
  endtask

  typedef struct {
    logic       rst_n;
    logic [2:0] en;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    logic [2:0] exp_tick;
    logic [2:0] exp_sq;
    logic       exp_err;
  } vec_t;

  vec_t vecs[23];

  logic [15:0] mask0, mask1, mask2;
  int          cnt_a, cnt_b;
  logic        prev_sq;

  initial begin
    rst_n = 0; en = 0;
    idle_inputs();

    // Vector table: reset, free-running period 5, then rejected and valid writes.
    for (int i = 0; i < 23; i++) begin
      int k;
      k = i - 2;
      vecs[i].rst_n  = (i >= 3);
      vecs[i].en     = (i >= 3) ? 3'b111 : 3'b000;
      vecs[i].wr_en  = 0;
      vecs[i].wr_ch  = 0;
      vecs[i].wr_div = 0;
      vecs[i].exp_err = 0;
      if (i < 3) begin
        vecs[i].exp_tick = 0;
        vecs[i].exp_sq   = 0;
      end else begin
        vecs[i].exp_tick = (k % 5 == 0) ? 3'b111 : 3'b000;
        vecs[i].exp_sq   = ((k / 5) % 2 == 1) ? 3'b111 : 3'b000;
      end
    end
    vecs[18].wr_en = 1; vecs[18].wr_ch = 3; vecs[18].wr_div = 4; vecs[18].exp_err = 1;
    vecs[19].wr_en = 1; vecs[19].wr_ch = 0; vecs[19].wr_div = 0; vecs[19].exp_err = 1;
    vecs[20].wr_en = 1; vecs[20].wr_ch = 2; vecs[20].wr_div = 5; vecs[20].exp_err = 0;

    for (int i = 0; i < 23; i++) begin
      rst_n = vecs[i].rst_n; en = vecs[i].en;
      wr_en = vecs[i].wr_en; wr_ch = vecs[i].wr_ch; wr_div = vecs[i].wr_div;
      step();
      check("vec_tick", 32'(tick), 32'(vecs[i].exp_tick));
      check("vec_sq", 32'(sq), 32'(vecs[i].exp_sq));
      check("vec_wr_err", 32'(wr_err), 32'(vecs[i].exp_err));
      $display("vec %0d: rst_n=%b en=%b wr=%b/%0d/%0d tick=%b sq=%b wr_err=%b",
               i, rst_n, en, wr_en, wr_ch, wr_div, tick, sq, wr_err);
    end

    // Pending writes: ch0 div=3 mid-period, ch1 div=2 exactly at its wrap.
    do_reset();
    en = 3'b111;
    mask0 = 0; mask1 = 0; mask2 = 0;
    for (int k = 1; k <= 15; k++) begin
      idle_inputs();
      if (k == 2) begin wr_en = 1; wr_ch = 0; wr_div = 3; end
      if (k == 5) begin wr_en = 1; wr_ch = 1; wr_div = 2; end
      step();
      mask0[k] = tick[0]; mask1[k] = tick[1]; mask2[k] = tick[2];
    end
    idle_inputs();
    check("pend_ch0_ticks", 32'(mask0), 32'(16'b0100_1001_0010_0000));
    check("pend_ch1_ticks", 32'(mask1), 32'(16'b0101_0100_0010_0000));
    check("pend_ch2_ticks", 32'(mask2), 32'(16'b1000_0100_0010_0000));
    $display("pend seq: tick0=%b tick1=%b tick2=%b", mask0, mask1, mask2);

    // Disable ch2 for 4 cycles at cnt2=2: tick delayed by 4.
    do_reset();
    mask2 = 0;
    for (int k = 1; k <= 15; k++) begin
      en = (k >= 3 && k <= 6) ? 3'b011 : 3'b111;
      step();
      mask2[k] = tick[2];
    end
    check("hold_ch2_ticks", 32'(mask2), 32'(16'b0100_0010_0000_0000));
    // Write div=7 while disabled, then measure distance to first tick.
    en = 3'b011; wr_en = 1; wr_ch = 2; wr_div = 7;
    step();
    idle_inputs();
    en = 3'b111;
    cnt_a = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (tick[2] && cnt_a == 0) cnt_a = k;
    end
    check("disabled_write_first_tick", 32'(cnt_a), 32'd7);
    $display("hold seq: tick2=%b first tick after write at %0d", mask2, cnt_a);

    // div=1 on disabled ch1: tick constantly high, sq toggles each cycle.
    en = 3'b101; wr_en = 1; wr_ch = 1; wr_div = 1;
    step();
    idle_inputs();
    en = 3'b111;
    cnt_a = 0; cnt_b = 0; prev_sq = sq[1];
    for (int k = 0; k < 6; k++) begin
      step();
      if (tick[1]) cnt_a++;
      if (sq[1] != prev_sq) cnt_b++;
      prev_sq = sq[1];
    end
    check("div1_tick_high", 32'(cnt_a), 32'd6);
    check("div1_sq_toggles", 32'(cnt_b), 32'd6);
    $display("div1 seq: tick1 high %0d/6, sq1 toggles %0d/6", cnt_a, cnt_b);

    // Reset mid-count with a pending divisor: pending value is lost.
    do_reset();
    en = 3'b111;
    repeat (2) step();
    wr_en = 1; wr_ch = 0; wr_div = 3;
    step();
    idle_inputs();
    step();
    rst_n = 0;
    step();
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_sq", 32'(sq), 32'd0);
    rst_n = 1;
    mask0 = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      mask0[k] = tick[0];
    end
    check("rst_pend_lost", 32'(mask0), 32'(16'b1000_0100_0010_0000));
    $display("reset seq: tick0=%b", mask0);

`ifdef TICK_SYNC_EN
    // Sync realigns all channels: ch0 loaded directly, ch1/ch2 via pending.
    en = 3'b111;
    repeat (2) step();
    wr_en = 1; wr_ch = 1; wr_div = 4; step();
    wr_ch = 2; wr_div = 4; step();
    wr_ch = 0; wr_div = 4; sync_in = 1; step();
    idle_inputs();
    check("sync_clear", 32'(tick) | 32'(sq), 32'd0);
    repeat (3) step();
    check("sync_pre", 32'(tick), 32'd0);
    step();
    check("sync_align", 32'(tick), 32'd7);
    $display("sync seq: tick=%b after 4 cycles", tick);
`endif

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      en      = 3'($urandom_range(0, 7));
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_div  = 8'($urandom_range(0, 9));
`ifdef TICK_SYNC_EN
      sync_in = ($urandom_range(0, 99) == 0);
`endif
      step();
    end
    idle_inputs();
    $display("random phase: 3000 cycles applied");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
